div_clk_checker: RTL and testbench

Self-test checker that consumes the divide-by-8 clock produced by the upstream divider and verifies it against `t_clk`. It samples the divided clock as data in the `t_clk` domain and measures each period and high phase in `t_clk` cycles. It counts mismatches over a programmed number of periods and reports pass/fail, with a timeout for a stuck clock. It sits directly downstream of the divider in the self-test path.

---
 rtl/clk_chk_pkg.sv | 23 ++
 rtl/div_clk_checker_edge_detect.sv | 45 ++++
 rtl/div_clk_checker.sv | 133 +++++++++++++
 tb/tb_div_clk_checker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_chk_pkg.sv
// Shared definitions for the self-test clock checkers: FSM states and timeout scaling.
package clk_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALIGN   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  // A missing edge is declared after this many expected periods.
  localparam int unsigned TIMEOUT_MULT = 4;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_ALIGN) || (s == ST_MEASURE);
  endfunction

  function automatic logic state_is_done(input state_e s);
    return (s == ST_DONE) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/div_clk_checker_edge_detect.sv
// Samples a clock-like signal as data and flags its rising/falling edges.
// With DIV_CLK_CHK_SYNC_EN defined, two synchronizer flops precede s0.
module edge_detect (
  input  logic t_clk,
  input  logic rst,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  logic s0_q, s0_d;
  logic s1_q, s1_d;

`ifdef DIV_CLK_CHK_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_in};
    s0_d   = sync_q[1];
  end

  always_ff @(posedge t_clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end
`else
  always_comb s0_d = d_in;
`endif

  always_comb s1_d = s0_q;

  always_ff @(posedge t_clk) begin
    if (rst) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign rise = s0_q & ~s1_q;
  assign fall = ~s0_q & s1_q;

endmodule

// File: rtl/div_clk_checker.sv
// Measures period and high phase of a divided clock in t_clk cycles and reports pass/fail.
// Optional input synchronizer: define DIV_CLK_CHK_SYNC_EN.
module div_clk_checker
  import clk_chk_pkg::*;
#(
  parameter int DIV_RATIO   = 8,
  parameter int NUM_PERIODS = 16,
  parameter int CNT_W       = 8,
  parameter int ERR_W       = 8
) (
  input  logic             t_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_clk_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] last_period
);

  localparam int PER_W = $clog2(NUM_PERIODS + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT_MULT * DIV_RATIO);
  localparam logic [CNT_W-1:0] FULL_PER  = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0] HALF_PER  = CNT_W'(DIV_RATIO / 2);
  localparam logic [PER_W-1:0] LAST_PER  = PER_W'(NUM_PERIODS);

  logic rise, fall;

  edge_detect u_edge (
    .t_clk (t_clk),
    .rst   (rst),
    .d_in  (div_clk_in),
    .rise  (rise),
    .fall  (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic [CNT_W-1:0] last_period_q, last_period_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    state_d       = state_q;
    cnt_d         = cnt_q;
    per_cnt_d     = per_cnt_q;
    err_d         = err_q;
    last_period_d = last_period_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    cnt_inc       = (cnt_q >= TO_LIMIT) ? TO_LIMIT : cnt_q + CNT_W'(1);
    err_inc       = (err_q == '1) ? err_q : err_q + ERR_W'(1);

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_d       = ST_ALIGN;
          cnt_d         = '0;
          per_cnt_d     = '0;
          err_d         = '0;
          last_period_d = '0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      ST_ALIGN: begin
        if (rise) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TO_LIMIT) begin
            state_d   = ST_FAIL;
            timeout_d = 1'b1;
          end
        end
      end
      ST_MEASURE: begin
        cnt_d = cnt_inc;
        if (fall && (cnt_q != HALF_PER)) err_d = err_inc;
        if (rise) begin
          // cnt_q holds the cycles since the previous rise, i.e. the period just closed.
          last_period_d = cnt_q;
          if (cnt_q != FULL_PER) err_d = err_inc;
          per_cnt_d = per_cnt_q + PER_W'(1);
          cnt_d     = CNT_W'(1);
          if (per_cnt_d == LAST_PER) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
          end
        end else if (cnt_inc >= TO_LIMIT) begin
          state_d   = ST_FAIL;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge t_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      per_cnt_q     <= '0;
      err_q         <= '0;
      last_period_q <= '0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      per_cnt_q     <= per_cnt_d;
      err_q         <= err_d;
      last_period_q <= last_period_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
    end
  end

  assign busy        = state_is_busy(state_q);
  assign done        = state_is_done(state_q);
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign err_cnt     = err_q;
  assign last_period = last_period_q;

endmodule

// File: tb/tb_div_clk_checker.sv
// Directed bench for div_clk_checker: an event-time model predicts every output on every cycle.
module tb_div_clk_checker;

  localparam int DIV     = 8;
  localparam int NUMP    = 16;
  localparam int CNT_W   = 8;
  localparam int ERR_W   = 8;
  localparam int TO_CYC  = 4 * DIV;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  localparam int MAXN    = 200;
`ifdef DIV_CLK_CHK_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  // An input change made before edge k is acted on by the checker at edge k+EV_LAT.
  localparam int EV_LAT = 1 + EXTRA;

  localparam int F_BUSY = 0, F_DONE = 1, F_PASS = 2, F_TO = 3, F_ERR = 4, F_LP = 5;

  logic             t_clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             div_clk_in = 1'b0;
  logic             busy, done, pass, timeout;
  logic [ERR_W-1:0] err_cnt;
  logic [CNT_W-1:0] last_period;

  div_clk_checker #(
    .DIV_RATIO(DIV), .NUM_PERIODS(NUMP), .CNT_W(CNT_W), .ERR_W(ERR_W)
  ) dut (
    .t_clk       (t_clk),
    .rst         (rst),
    .start       (start),
    .div_clk_in  (div_clk_in),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .err_cnt     (err_cnt),
    .last_period (last_period)
  );

  always #5 t_clk = ~t_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wave     [MAXN];
  int exp_busy [MAXN];
  int exp_done [MAXN];
  int exp_pass [MAXN];
  int exp_to   [MAXN];
  int exp_err  [MAXN];
  int exp_lp   [MAXN];
  int cur_k      = 0;
  bit chk_en     = 1'b0;
  int first_done = -1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cur_k, act, exp);
    end
  endtask

  task automatic set_tail(input int field, input int from, input int n, input int val);
    for (int k = (from < 0 ? 0 : from); k < n; k++)
      case (field)
        F_BUSY:  exp_busy[k] = val;
        F_DONE:  exp_done[k] = val;
        F_PASS:  exp_pass[k] = val;
        F_TO:    exp_to[k]   = val;
        F_ERR:   exp_err[k]  = val;
        default: exp_lp[k]   = val;
      endcase
  endtask

  // Works on the list of input edge times: periods and high phases are differences of times.
  task automatic build_model(input int n, input int rst_at);
    int ev_t[$];
    int ev_r[$];
    int prev, a, ai, last, err, per, end_t, ok;
    prev = 0;
    for (int k = 0; k < n; k++)
      if (wave[k] != prev) begin
        ev_t.push_back(k + EV_LAT);
        ev_r.push_back(wave[k]);
        prev = wave[k];
      end
    set_tail(F_BUSY, 0, n, 1);
    set_tail(F_DONE, 0, n, 0);
    set_tail(F_PASS, 0, n, 0);
    set_tail(F_TO,   0, n, 0);
    set_tail(F_ERR,  0, n, 0);
    set_tail(F_LP,   0, n, 0);
    a = -1; ai = 0; last = 0; err = 0; per = 0; end_t = -1; ok = 0;
    for (int i = 0; i < ev_t.size(); i++)
      if (a < 0 && ev_r[i] == 1) begin
        a  = ev_t[i];
        ai = i;
      end
    if (a < 0 || a > TO_CYC) end_t = TO_CYC;
    else begin
      last = a;
      for (int i = ai + 1; i < ev_t.size(); i++)
        if (end_t < 0) begin
          // The count restarts at 1 on each rise, so it hits the limit TO_CYC-1 edges later.
          if (ev_t[i] > last + TO_CYC - 1) end_t = last + TO_CYC - 1;
          else if (ev_r[i] == 0) begin
            if (ev_t[i] - last != DIV / 2) begin
              err++;
              set_tail(F_ERR, ev_t[i], n, (err > ERR_MAX) ? ERR_MAX : err);
            end
          end else begin
            set_tail(F_LP, ev_t[i], n, ev_t[i] - last);
            if (ev_t[i] - last != DIV) begin
              err++;
              set_tail(F_ERR, ev_t[i], n, (err > ERR_MAX) ? ERR_MAX : err);
            end
            per++;
            last = ev_t[i];
            if (per == NUMP) begin
              end_t = last;
              ok    = 1;
            end
          end
        end
      if (end_t < 0 && last + TO_CYC - 1 < n) end_t = last + TO_CYC - 1;
    end
    if (end_t >= 0) begin
      set_tail(F_BUSY, end_t, n, 0);
      set_tail(F_DONE, end_t, n, 1);
      set_tail(F_PASS, end_t, n, (ok == 1 && err == 0) ? 1 : 0);
      set_tail(F_TO,   end_t, n, ok ? 0 : 1);
    end
    if (rst_at >= 0) begin
      set_tail(F_BUSY, rst_at, n, 0);
      set_tail(F_DONE, rst_at, n, 0);
      set_tail(F_PASS, rst_at, n, 0);
      set_tail(F_TO,   rst_at, n, 0);
      set_tail(F_ERR,  rst_at, n, 0);
      set_tail(F_LP,   rst_at, n, 0);
    end
  endtask

  always @(negedge t_clk) begin
    if (chk_en) begin
      check("busy",        int'(busy),        exp_busy[cur_k]);
      check("done",        int'(done),        exp_done[cur_k]);
      check("pass",        int'(pass),        exp_pass[cur_k]);
      check("timeout",     int'(timeout),     exp_to[cur_k]);
      check("err_cnt",     int'(err_cnt),     exp_err[cur_k]);
      check("last_period", int'(last_period), exp_lp[cur_k]);
      if (done && first_done < 0) first_done = cur_k;
    end
  end

  // Low for `prefix` cycles, then periods of h high / l low; period `odd_idx` uses oh/ol.
  task automatic gen_wave(input int prefix, input int odd_idx, input int oh, input int ol,
                          input int h, input int l);
    int k, hh, ll, p;
    k = 0;
    p = 0;
    for (int i = 0; i < MAXN; i++) wave[i] = 0;
    k = prefix;
    while (k < MAXN) begin
      hh = (p == odd_idx) ? oh : h;
      ll = (p == odd_idx) ? ol : l;
      for (int i = 0; i < hh && k < MAXN; i++) wave[k++] = 1;
      for (int i = 0; i < ll && k < MAXN; i++) wave[k++] = 0;
      p++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    div_clk_in = 1'b0;
    repeat (6) @(posedge t_clk);
    #1 rst = 1'b0;
    check("rst_busy",    int'(busy),        0);
    check("rst_done",    int'(done),        0);
    check("rst_pass",    int'(pass),        0);
    check("rst_timeout", int'(timeout),     0);
    check("rst_err",     int'(err_cnt),     0);
    check("rst_lp",      int'(last_period), 0);
  endtask

  // Edge 0 of the window is the edge that samples start.
  task automatic run_scn(input int n, input int repulse, input int rst_at);
    build_model(n, rst_at);
    first_done = -1;
    for (int k = 0; k < n; k++) begin
      start      = (k == 0) || (k == repulse);
      rst        = (k == rst_at);
      div_clk_in = wave[k][0];
      @(posedge t_clk);
      cur_k  = k;
      chk_en = 1'b1;
      #1;
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge t_clk);
    #1 chk_en = 1'b0;
  endtask

  task automatic check_result(input string tag, input int e_pass, input int e_to,
                              input int e_err, input int e_lp);
    check({tag, "_done"},    int'(done),        1);
    check({tag, "_pass"},    int'(pass),        e_pass);
    check({tag, "_timeout"}, int'(timeout),     e_to);
    check({tag, "_err"},     int'(err_cnt),     e_err);
    check({tag, "_lp"},      int'(last_period), e_lp);
    check({tag, "_busy"},    int'(busy),        0);
  endtask

  initial begin
    // Ideal divider: first rise aligns, 16 more rises 8 apart.
    do_reset();
    gen_wave(3, -1, 0, 0, 4, 4);
    run_scn(150, -1, -1);
    check_result("ideal", 1, 0, 0, 8);
    check("ideal_done_cycle", first_done, 132 + EXTRA);

    // Stuck low: FAIL 32 cycles after entering ALIGN.
    do_reset();
    for (int i = 0; i < MAXN; i++) wave[i] = 0;
    run_scn(45, -1, -1);
    check_result("stuck", 0, 1, 0, 0);
    check("stuck_done_cycle", first_done, 32);

    // One 5/5 period: a high-phase error and a period error.
    do_reset();
    gen_wave(3, 5, 5, 5, 4, 4);
    run_scn(150, -1, -1);
    check_result("odd", 0, 0, 2, 8);

    // Duty 3/5: a high-phase error on each of the 16 measured periods.
    do_reset();
    gen_wave(3, -1, 0, 0, 3, 5);
    run_scn(150, -1, -1);
    check_result("duty", 0, 0, 16, 8);

    // Restart from DONE without reset, with start re-pulsed mid-MEASURE.
    div_clk_in = 1'b0;
    repeat (6) @(posedge t_clk);
    #1;
    gen_wave(3, -1, 0, 0, 4, 4);
    run_scn(150, 40, -1);
    check_result("restart", 1, 0, 0, 8);

    // Reset mid-MEASURE: everything back to zero on the next edge.
    do_reset();
    gen_wave(3, -1, 0, 0, 4, 4);
    run_scn(80, -1, 60);
    check("midrst_busy", int'(busy),        0);
    check("midrst_done", int'(done),        0);
    check("midrst_err",  int'(err_cnt),     0);
    check("midrst_lp",   int'(last_period), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
